// File: rtl/bru_pkg.sv
// Shared state encoding, queue entry layout and default parameters for branch_resolve_unit.
package bru_pkg;

  localparam int BRU_PC_W         = 10;
  localparam int BRU_DEPTH        = 4;
  localparam int BRU_FLUSH_CYCLES = 2;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } bru_state_e;

  // Reference layout at the default width; modules rebuild it locally at their own PC_W.
  typedef struct packed {
    logic [BRU_PC_W-1:0] pc;
    logic                taken;
    logic [BRU_PC_W-1:0] target;
  } bru_entry_t;

  function automatic int bruEntryWidth(input int pcW);
    return 2 * pcW + 1;
  endfunction

endpackage

// File: rtl/bru_if.sv
// Decode/execute/predictor signal bundle for branch_resolve_unit.
// The stat_* counters exist only when BRU_STATS_EN is defined.
interface bru_if #(
  parameter int PC_W = bru_pkg::BRU_PC_W
);

  logic            pred_valid;
  logic            pred_taken;
  logic [PC_W-1:0] pred_pc;
  logic [PC_W-1:0] pred_target;
  logic            pred_ready;

  logic            res_valid;
  logic            res_taken;
  logic [PC_W-1:0] res_pc;

  logic            update_enable;
  logic            update_value;
  logic [PC_W-1:0] update_pc;

  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            flush;
  logic            protocol_err;

`ifdef BRU_STATS_EN
  logic [15:0]     stat_branches;
  logic [15:0]     stat_mispredicts;
`endif

  modport master (
    output pred_valid, pred_taken, pred_pc, pred_target,
    output res_valid, res_taken, res_pc,
    input  pred_ready, update_enable, update_value, update_pc,
    input  redirect_valid, redirect_pc, flush, protocol_err
`ifdef BRU_STATS_EN
    , input stat_branches, stat_mispredicts
`endif
  );

  modport slave (
    input  pred_valid, pred_taken, pred_pc, pred_target,
    input  res_valid, res_taken, res_pc,
    output pred_ready, update_enable, update_value, update_pc,
    output redirect_valid, redirect_pc, flush, protocol_err
`ifdef BRU_STATS_EN
    , output stat_branches, stat_mispredicts
`endif
  );

endinterface

// File: rtl/bru_pred_queue.sv
// In-order queue of decode-stage predictions; clear wins over push and pop in the same cycle.
module bru_pred_queue #(
  parameter int ENTRY_W = 21,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] data_i,
  input  logic               pop_i,
  input  logic               clear_i,
  output logic               full_o,
  output logic               empty_o,
  output logic [ENTRY_W-1:0] head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (clear_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push_i) wrPtr_d = wrPtr_q + PTR_W'(1);
      if (pop_i)  rdPtr_d = rdPtr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wrPtr_q] <= data_i;
  end

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rdPtr_q];

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves queued branch predictions in Execute, drives predictor updates, redirects and flush.
// Optional saturating branch/mispredict counters are enabled with BRU_STATS_EN.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int PC_W         = BRU_PC_W,
  parameter int DEPTH        = BRU_DEPTH,
  parameter int FLUSH_CYCLES = BRU_FLUSH_CYCLES
) (
  input logic  clk,
  input logic  reset,
  bru_if.slave bus
);

  localparam int ENTRY_W = bruEntryWidth(PC_W);
  localparam int FC_W    = $clog2(FLUSH_CYCLES + 1);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            taken;
    logic [PC_W-1:0] target;
  } entry_t;

  bru_state_e      state_q, state_d;
  logic [FC_W-1:0] flushCnt_q, flushCnt_d;
  logic            updEn_q, updEn_d;
  logic            updVal_q, updVal_d;
  logic [PC_W-1:0] updPc_q, updPc_d;
  logic            redirValid_q, redirValid_d;
  logic [PC_W-1:0] redirPc_q, redirPc_d;
  logic            protoErr_q, protoErr_d;

  entry_t pushEntry;
  entry_t head;
  logic   qFull, qEmpty;
  logic   predReady, push, pop, clear;

  // No bypass: a full queue refuses a push even when the head pops this cycle.
  assign predReady = !reset && (state_q == RUN) && !qFull;
  assign push      = bus.pred_valid && predReady;
  assign pushEntry = '{pc: bus.pred_pc, taken: bus.pred_taken, target: bus.pred_target};

  bru_pred_queue #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  (pushEntry),
    .pop_i   (pop),
    .clear_i (clear),
    .full_o  (qFull),
    .empty_o (qEmpty),
    .head_o  (head)
  );

  always_comb begin
    state_d      = state_q;
    flushCnt_d   = flushCnt_q;
    updEn_d      = 1'b0;
    updVal_d     = 1'b0;
    updPc_d      = '0;
    redirValid_d = 1'b0;
    redirPc_d    = '0;
    protoErr_d   = protoErr_q;
    pop          = 1'b0;
    clear        = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.res_valid) begin
          updEn_d  = 1'b1;
          updVal_d = bus.res_taken;
          updPc_d  = bus.res_pc;
          if (qEmpty) begin
            protoErr_d = 1'b1;
          end else begin
            pop = 1'b1;
            if (bus.res_pc != head.pc) protoErr_d = 1'b1;
            if (head.taken != bus.res_taken) begin
              clear        = 1'b1;
              redirValid_d = 1'b1;
              redirPc_d    = bus.res_taken ? head.target : head.pc + PC_W'(1);
              state_d      = FLUSH;
              flushCnt_d   = FC_W'(FLUSH_CYCLES);
            end
          end
        end
      end
      FLUSH: begin
        if (flushCnt_q == FC_W'(1)) begin
          state_d    = RUN;
          flushCnt_d = '0;
        end else begin
          flushCnt_d = flushCnt_q - FC_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      flushCnt_q   <= '0;
      updEn_q      <= 1'b0;
      updVal_q     <= 1'b0;
      updPc_q      <= '0;
      redirValid_q <= 1'b0;
      redirPc_q    <= '0;
      protoErr_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      flushCnt_q   <= flushCnt_d;
      updEn_q      <= updEn_d;
      updVal_q     <= updVal_d;
      updPc_q      <= updPc_d;
      redirValid_q <= redirValid_d;
      redirPc_q    <= redirPc_d;
      protoErr_q   <= protoErr_d;
    end
  end

  assign bus.pred_ready     = predReady;
  assign bus.update_enable  = updEn_q;
  assign bus.update_value   = updVal_q;
  assign bus.update_pc      = updPc_q;
  assign bus.redirect_valid = redirValid_q;
  assign bus.redirect_pc    = redirPc_q;
  assign bus.flush          = (state_q == FLUSH);
  assign bus.protocol_err   = protoErr_q;

`ifdef BRU_STATS_EN
  logic [15:0] statBr_q, statBr_d;
  logic [15:0] statMis_q, statMis_d;

  // Every RUN-state resolve yields exactly one update pulse, and every mispredict one redirect.
  always_comb begin
    statBr_d  = statBr_q;
    statMis_d = statMis_q;
    if (updEn_q && statBr_q != 16'hFFFF)       statBr_d  = statBr_q + 16'd1;
    if (redirValid_q && statMis_q != 16'hFFFF) statMis_d = statMis_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      statBr_q  <= '0;
      statMis_q <= '0;
    end else begin
      statBr_q  <= statBr_d;
      statMis_q <= statMis_d;
    end
  end

  assign bus.stat_branches    = statBr_q;
  assign bus.stat_mispredicts = statMis_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus randomized traffic
// checked against a queue-based reference model. Stats checks compile in with BRU_STATS_EN.
module tb_branch_resolve_unit;

  localparam int PC_W         = 10;
  localparam int DEPTH        = 4;
  localparam int FLUSH_CYCLES = 2;
  localparam int PC_MOD       = 1 << PC_W;

  logic clk;
  logic reset;

  bru_if #(.PC_W(PC_W)) bus ();

  branch_resolve_unit #(
    .PC_W         (PC_W),
    .DEPTH        (DEPTH),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int pc;
    bit taken;
    int target;
  } mEnt_t;

  mEnt_t mq[$];
  int    flushLeft;
  bit    errM;
  int    statB, statM;

  bit              eUpdEn, eUpdVal, eRedV, eFlush, eReady, eErr;
  logic [PC_W-1:0] eUpdPc, eRedPc;

  int testsRun;
  int testsFailed;

  task automatic setIn(input bit pv, input bit pt, input int pp, input int ptg,
                       input bit rv, input bit rt, input int rp);
    bus.pred_valid  = pv;
    bus.pred_taken  = pt;
    bus.pred_pc     = PC_W'(pp);
    bus.pred_target = PC_W'(ptg);
    bus.res_valid   = rv;
    bus.res_taken   = rt;
    bus.res_pc      = PC_W'(rp);
  endtask

  // Reference model: advances one clock from the current inputs, then samples 1ns after the edge.
  task automatic tick();
    bit    rdy;
    bit    clearQ;
    mEnt_t h;
    rdy = (flushLeft == 0) && (mq.size() < DEPTH);
    if (reset) begin
      statB = 0;
      statM = 0;
    end else begin
      if (eUpdEn && statB < 65535) statB++;
      if (eRedV && statM < 65535)  statM++;
    end
    eUpdEn = 0; eUpdVal = 0; eUpdPc = '0; eRedV = 0; eRedPc = '0;
    if (reset) begin
      mq.delete();
      flushLeft = 0;
      errM = 0;
    end else if (flushLeft > 0) begin
      flushLeft--;
    end else begin
      clearQ = 0;
      if (bus.res_valid) begin
        eUpdEn  = 1;
        eUpdVal = bus.res_taken;
        eUpdPc  = bus.res_pc;
        if (mq.size() == 0) begin
          errM = 1;
        end else begin
          h = mq.pop_front();
          if (h.pc != int'(bus.res_pc)) errM = 1;
          if (h.taken != bus.res_taken) begin
            eRedV     = 1;
            eRedPc    = bus.res_taken ? PC_W'(h.target) : PC_W'((h.pc + 1) % PC_MOD);
            clearQ    = 1;
            flushLeft = FLUSH_CYCLES;
          end
        end
      end
      if (clearQ) mq.delete();
      else if (bus.pred_valid && rdy)
        mq.push_back('{pc: int'(bus.pred_pc), taken: bus.pred_taken, target: int'(bus.pred_target)});
    end
    @(posedge clk);
    #1;
    eFlush = (flushLeft > 0);
    eReady = !reset && (flushLeft == 0) && (mq.size() < DEPTH);
    eErr   = errM;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    setIn(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    testsRun++; if (bus.update_enable !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_upd_en got %0b want 0", bus.update_enable); end
    testsRun++; if (bus.redirect_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_redir got %0b want 0", bus.redirect_valid); end
    testsRun++; if (bus.flush !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_flush got %0b want 0", bus.flush); end
    testsRun++; if (bus.protocol_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_err got %0b want 0", bus.protocol_err); end
    testsRun++; if (bus.pred_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ready_during got %0b want 0", bus.pred_ready); end
    reset = 1'b0;
    tick();
    testsRun++; if (bus.pred_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_ready_after got %0b want 1", bus.pred_ready); end
    testsRun++; if (bus.update_pc !== 10'd0) begin testsFailed++; $display("[TB] FAIL reset_upd_pc got %0d want 0", bus.update_pc); end
  endtask

  task automatic test_correct();
    setIn(1, 1, 5, 20, 0, 0, 0);
    tick();
    setIn(0, 0, 0, 0, 1, 1, 5);
    tick();
    testsRun++; if (bus.update_enable !== 1'b1) begin testsFailed++; $display("[TB] FAIL corr_upd_en got %0b want 1", bus.update_enable); end
    testsRun++; if (bus.update_value !== 1'b1) begin testsFailed++; $display("[TB] FAIL corr_upd_val got %0b want 1", bus.update_value); end
    testsRun++; if (bus.update_pc !== 10'd5) begin testsFailed++; $display("[TB] FAIL corr_upd_pc got %0d want 5", bus.update_pc); end
    testsRun++; if (bus.redirect_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL corr_redir got %0b want 0", bus.redirect_valid); end
    testsRun++; if (bus.flush !== 1'b0) begin testsFailed++; $display("[TB] FAIL corr_flush got %0b want 0", bus.flush); end
    setIn(0, 0, 0, 0, 0, 0, 0);
    tick();
    testsRun++; if (bus.update_enable !== 1'b0) begin testsFailed++; $display("[TB] FAIL corr_upd_one_cycle got %0b want 0", bus.update_enable); end
  endtask

  task automatic test_mispredict();
    setIn(1, 1, 7, 30, 0, 0, 0);
    tick();
    setIn(0, 0, 0, 0, 1, 0, 7);
    tick();
    testsRun++; if (bus.redirect_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL mis_redir got %0b want 1", bus.redirect_valid); end
    testsRun++; if (bus.redirect_pc !== 10'd8) begin testsFailed++; $display("[TB] FAIL mis_redir_pc got %0d want 8", bus.redirect_pc); end
    testsRun++; if (bus.update_value !== 1'b0) begin testsFailed++; $display("[TB] FAIL mis_upd_val got %0b want 0", bus.update_value); end
    testsRun++; if (bus.flush !== 1'b1) begin testsFailed++; $display("[TB] FAIL mis_flush1 got %0b want 1", bus.flush); end
    testsRun++; if (bus.pred_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL mis_ready1 got %0b want 0", bus.pred_ready); end
    // A resolve arriving during the flush window must be ignored entirely.
    setIn(1, 0, 9, 9, 1, 1, 7);
    tick();
    testsRun++; if (bus.flush !== 1'b1) begin testsFailed++; $display("[TB] FAIL mis_flush2 got %0b want 1", bus.flush); end
    testsRun++; if (bus.redirect_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL mis_redir_one got %0b want 0", bus.redirect_valid); end
    testsRun++; if (bus.update_enable !== 1'b0) begin testsFailed++; $display("[TB] FAIL mis_ignored_res got %0b want 0", bus.update_enable); end
    testsRun++; if (bus.pred_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL mis_ready2 got %0b want 0", bus.pred_ready); end
    setIn(0, 0, 0, 0, 0, 0, 0);
    tick();
    testsRun++; if (bus.flush !== 1'b0) begin testsFailed++; $display("[TB] FAIL mis_flush_end got %0b want 0", bus.flush); end
    testsRun++; if (bus.pred_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL mis_ready_end got %0b want 1", bus.pred_ready); end
    testsRun++; if (bus.protocol_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL mis_no_err got %0b want 0", bus.protocol_err); end
  endtask

  task automatic test_wrap();
    setIn(1, 0, 1023, 3, 0, 0, 0);
    tick();
    setIn(0, 0, 0, 0, 1, 1, 1023);
    tick();
    testsRun++; if (bus.redirect_pc !== 10'd3) begin testsFailed++; $display("[TB] FAIL wrap_target got %0d want 3", bus.redirect_pc); end
    setIn(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    setIn(1, 1, 1023, 3, 0, 0, 0);
    tick();
    setIn(0, 0, 0, 0, 1, 0, 1023);
    tick();
    testsRun++; if (bus.redirect_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL wrap_redir got %0b want 1", bus.redirect_valid); end
    testsRun++; if (bus.redirect_pc !== 10'd0) begin testsFailed++; $display("[TB] FAIL wrap_fallthru got %0d want 0", bus.redirect_pc); end
    setIn(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
  endtask

  task automatic test_full();
    int expPcs[4] = '{202, 203, 205, 206};
    for (int i = 0; i < 4; i++) begin
      setIn(1, (200 + i) % 2 == 1, 200 + i, 210 + i, 0, 0, 0);
      tick();
    end
    testsRun++; if (bus.pred_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_ready got %0b want 0", bus.pred_ready); end
    setIn(1, 0, 204, 214, 1, 0, 200);
    tick();
    testsRun++; if (bus.pred_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL full_nobypass got %0b want 1", bus.pred_ready); end
    testsRun++; if (bus.update_pc !== 10'd200) begin testsFailed++; $display("[TB] FAIL full_pop_pc got %0d want 200", bus.update_pc); end
    setIn(1, 1, 205, 215, 1, 1, 201);
    tick();
    testsRun++; if (bus.pred_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL full_pushpop got %0b want 1", bus.pred_ready); end
    setIn(1, 0, 206, 216, 0, 0, 0);
    tick();
    testsRun++; if (bus.pred_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_refill got %0b want 0", bus.pred_ready); end
    for (int i = 0; i < 4; i++) begin
      setIn(0, 0, 0, 0, 1, expPcs[i] % 2 == 1, expPcs[i]);
      tick();
      testsRun++; if (bus.update_enable !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_upd_en[%0d] got %0b want 1", i, bus.update_enable); end
      testsRun++; if (bus.update_pc !== PC_W'(expPcs[i])) begin testsFailed++; $display("[TB] FAIL b2b_upd_pc[%0d] got %0d want %0d", i, bus.update_pc, expPcs[i]); end
      testsRun++; if (bus.redirect_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_redir[%0d] got %0b want 0", i, bus.redirect_valid); end
    end
    setIn(0, 0, 0, 0, 0, 0, 0);
    tick();
    testsRun++; if (bus.protocol_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_no_err got %0b want 0", bus.protocol_err); end
  endtask

  task automatic test_protocol();
    setIn(0, 0, 0, 0, 1, 1, 9);
    tick();
    testsRun++; if (bus.update_enable !== 1'b1) begin testsFailed++; $display("[TB] FAIL orphan_upd got %0b want 1", bus.update_enable); end
    testsRun++; if (bus.update_pc !== 10'd9) begin testsFailed++; $display("[TB] FAIL orphan_upd_pc got %0d want 9", bus.update_pc); end
    testsRun++; if (bus.redirect_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL orphan_redir got %0b want 0", bus.redirect_valid); end
    testsRun++; if (bus.protocol_err !== 1'b1) begin testsFailed++; $display("[TB] FAIL orphan_err got %0b want 1", bus.protocol_err); end
    setIn(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    testsRun++; if (bus.protocol_err !== 1'b1) begin testsFailed++; $display("[TB] FAIL err_sticky got %0b want 1", bus.protocol_err); end
    setIn(1, 0, 50, 60, 0, 0, 0);
    tick();
    setIn(0, 0, 0, 0, 1, 0, 51);
    tick();
    testsRun++; if (bus.update_pc !== 10'd51) begin testsFailed++; $display("[TB] FAIL pcmis_upd_pc got %0d want 51", bus.update_pc); end
    testsRun++; if (bus.redirect_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL pcmis_redir got %0b want 0", bus.redirect_valid); end
    testsRun++; if (bus.protocol_err !== 1'b1) begin testsFailed++; $display("[TB] FAIL pcmis_err got %0b want 1", bus.protocol_err); end
    // Three more pushes leave room only if the mismatched head really popped.
    for (int i = 0; i < 3; i++) begin
      setIn(1, (80 + i) % 2 == 1, 80 + i, 90 + i, 0, 0, 0);
      tick();
    end
    testsRun++; if (bus.pred_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL pcmis_popped got %0b want 1", bus.pred_ready); end
    setIn(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_in_flush();
    setIn(0, 0, 0, 0, 1, 1, 80);
    tick();
    testsRun++; if (bus.redirect_pc !== 10'd90) begin testsFailed++; $display("[TB] FAIL rif_redir_pc got %0d want 90", bus.redirect_pc); end
    testsRun++; if (bus.flush !== 1'b1) begin testsFailed++; $display("[TB] FAIL rif_flush got %0b want 1", bus.flush); end
    setIn(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    testsRun++; if (bus.flush !== 1'b0) begin testsFailed++; $display("[TB] FAIL rif_flush_clr got %0b want 0", bus.flush); end
    testsRun++; if (bus.update_enable !== 1'b0) begin testsFailed++; $display("[TB] FAIL rif_upd got %0b want 0", bus.update_enable); end
    testsRun++; if (bus.redirect_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rif_redir got %0b want 0", bus.redirect_valid); end
    testsRun++; if (bus.redirect_pc !== 10'd0) begin testsFailed++; $display("[TB] FAIL rif_redir_pc0 got %0d want 0", bus.redirect_pc); end
    testsRun++; if (bus.protocol_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL rif_err got %0b want 0", bus.protocol_err); end
    reset = 1'b0;
    tick();
    testsRun++; if (bus.pred_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL rif_ready got %0b want 1", bus.pred_ready); end
    testsRun++; if (bus.flush !== 1'b0) begin testsFailed++; $display("[TB] FAIL rif_run got %0b want 0", bus.flush); end
  endtask

`ifdef BRU_STATS_EN
  task automatic test_stats();
    setIn(1, 1, 300, 5, 0, 0, 0);   tick();
    setIn(0, 0, 0, 0, 1, 1, 300);   tick();
    setIn(1, 0, 301, 6, 0, 0, 0);   tick();
    setIn(0, 0, 0, 0, 1, 0, 301);   tick();
    setIn(1, 1, 302, 7, 0, 0, 0);   tick();
    setIn(0, 0, 0, 0, 1, 0, 302);   tick();
    setIn(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    testsRun++; if (bus.stat_branches !== 16'd3) begin testsFailed++; $display("[TB] FAIL stat_branches got %0d want 3", bus.stat_branches); end
    testsRun++; if (bus.stat_mispredicts !== 16'd1) begin testsFailed++; $display("[TB] FAIL stat_mispredicts got %0d want 1", bus.stat_mispredicts); end
  endtask
`endif

  task automatic test_random();
    bit rv, rt;
    int rp;
    for (int n = 0; n < 400; n++) begin
      rv = ($urandom % 100) < 45;
      if (mq.size() > 0 && ($urandom % 10) < 9) rp = mq[0].pc;
      else rp = int'($urandom % PC_MOD);
      if (mq.size() > 0 && ($urandom % 4) != 0) rt = mq[0].taken;
      else rt = $urandom % 2;
      setIn(($urandom % 100) < 60, $urandom % 2, int'($urandom % PC_MOD), int'($urandom % PC_MOD), rv, rt, rp);
      reset = (($urandom % 100) == 0);
      tick();
      testsRun++; if (bus.update_enable !== eUpdEn) begin testsFailed++; $display("[TB] FAIL rnd_upd_en[%0d] got %0b want %0b", n, bus.update_enable, eUpdEn); end
      testsRun++; if (bus.update_value !== eUpdVal) begin testsFailed++; $display("[TB] FAIL rnd_upd_val[%0d] got %0b want %0b", n, bus.update_value, eUpdVal); end
      testsRun++; if (bus.update_pc !== eUpdPc) begin testsFailed++; $display("[TB] FAIL rnd_upd_pc[%0d] got %0d want %0d", n, bus.update_pc, eUpdPc); end
      testsRun++; if (bus.redirect_valid !== eRedV) begin testsFailed++; $display("[TB] FAIL rnd_redir[%0d] got %0b want %0b", n, bus.redirect_valid, eRedV); end
      testsRun++; if (bus.redirect_pc !== eRedPc) begin testsFailed++; $display("[TB] FAIL rnd_redir_pc[%0d] got %0d want %0d", n, bus.redirect_pc, eRedPc); end
      testsRun++; if (bus.flush !== eFlush) begin testsFailed++; $display("[TB] FAIL rnd_flush[%0d] got %0b want %0b", n, bus.flush, eFlush); end
      testsRun++; if (bus.pred_ready !== eReady) begin testsFailed++; $display("[TB] FAIL rnd_ready[%0d] got %0b want %0b", n, bus.pred_ready, eReady); end
      testsRun++; if (bus.protocol_err !== eErr) begin testsFailed++; $display("[TB] FAIL rnd_err[%0d] got %0b want %0b", n, bus.protocol_err, eErr); end
`ifdef BRU_STATS_EN
      testsRun++; if (bus.stat_branches !== 16'(statB)) begin testsFailed++; $display("[TB] FAIL rnd_stat_br[%0d] got %0d want %0d", n, bus.stat_branches, statB); end
      testsRun++; if (bus.stat_mispredicts !== 16'(statM)) begin testsFailed++; $display("[TB] FAIL rnd_stat_mis[%0d] got %0d want %0d", n, bus.stat_mispredicts, statM); end
`endif
    end
    reset = 1'b0;
    setIn(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    flushLeft   = 0;
    errM        = 0;
    statB       = 0;
    statM       = 0;
    eUpdEn = 0; eUpdVal = 0; eUpdPc = '0; eRedV = 0; eRedPc = '0;
    eFlush = 0; eReady = 0; eErr = 0;
    reset = 1'b1;
    setIn(0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_correct();
    test_mispredict();
    test_wrap();
    test_full();
    test_protocol();
    test_reset_in_flush();
`ifdef BRU_STATS_EN
    test_stats();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
